// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with valid/ready request and response.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | iterating, counter counts N down to 0
// DONE  | result held until consumer accepts
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [7:0]      mdu_info_i,
    input  logic            op_w_i,
    input  logic [XLEN-1:0] rs1_rdata_i,
    input  logic [XLEN-1:0] rs2_rdata_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] mdu_res_o
);
    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [6:0]        cnt;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     opa;
    logic [XLEN-1:0]   opb;
    logic              is_mul, mul_high, is_rem, neg, w_q;

    function automatic logic [XLEN-1:0] w_fix(input logic [XLEN-1:0] v, input logic w);
        return w ? XLEN'($signed(v[31:0])) : v;
    endfunction

    logic            req_w, sgn_a, sgn_b, sa, sb, one_hot, is_div_req, ovf, fast;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, div_dvd, fast_raw, fast_res;

    always_comb begin
        req_w   = (XLEN == 64) && op_w_i;
        sgn_a   = mdu_info_i[0] | mdu_info_i[1] | mdu_info_i[2] | mdu_info_i[4] | mdu_info_i[6];
        sgn_b   = mdu_info_i[0] | mdu_info_i[1] | mdu_info_i[4] | mdu_info_i[6];
        a_ext   = rs1_rdata_i;
        b_ext   = rs2_rdata_i;
        if (req_w) begin
            a_ext = sgn_a ? XLEN'($signed(rs1_rdata_i[31:0])) : XLEN'(rs1_rdata_i[31:0]);
            b_ext = sgn_b ? XLEN'($signed(rs2_rdata_i[31:0])) : XLEN'(rs2_rdata_i[31:0]);
        end
        sa      = sgn_a & a_ext[XLEN-1];
        sb      = sgn_b & b_ext[XLEN-1];
        a_mag   = sa ? -a_ext : a_ext;
        b_mag   = sb ? -b_ext : b_ext;
        // W-mode dividend sits at the top so the MSB-first loop runs only 32 steps
        div_dvd = req_w ? (a_mag << (XLEN - 32)) : a_mag;
        min_neg = req_w ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        one_hot = (mdu_info_i != 8'd0) && ((mdu_info_i & (mdu_info_i - 8'd1)) == 8'd0);
        is_div_req = |mdu_info_i[7:4];
        ovf     = (mdu_info_i[4] | mdu_info_i[6]) && (a_ext == min_neg) && (b_ext == '1);
        fast    = !one_hot || (is_div_req && (b_ext == '0)) || ovf;
        fast_raw = '0;
        if (!one_hot)
            fast_raw = '0;
        else if (is_div_req && (b_ext == '0))
            fast_raw = (mdu_info_i[4] | mdu_info_i[5]) ? '1 : a_ext;
        else if (ovf)
            fast_raw = mdu_info_i[4] ? a_ext : '0;
        fast_res = w_fix(fast_raw, req_w);
    end

    logic [PW-1:0]   mul_acc_nx, prod;
    logic [XLEN:0]   div_sh;
    logic            div_ok;
    logic [XLEN-1:0] rem_nx, q_nx, quo, rm, mul_r, calc_res;

    always_comb begin
        mul_acc_nx = acc + (opb[0] ? opa : '0);
        div_sh     = {acc[XLEN-1:0], opa[XLEN-1]};
        div_ok     = div_sh >= {1'b0, opb};
        rem_nx     = div_ok ? XLEN'(div_sh - {1'b0, opb}) : div_sh[XLEN-1:0];
        q_nx       = {opa[XLEN-2:0], div_ok};
        prod       = neg ? -mul_acc_nx : mul_acc_nx;
        mul_r      = prod[XLEN-1:0];
        if (mul_high)
            mul_r = w_q ? XLEN'(prod[63:32]) : prod[PW-1:XLEN];
        quo        = neg ? -q_nx : q_nx;
        rm         = neg ? -rem_nx : rem_nx;
        calc_res   = w_fix(is_mul ? mul_r : (is_rem ? rm : quo), w_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            mdu_res_o    <= '0;
            cnt          <= '0;
            acc          <= '0;
            opa          <= '0;
            opb          <= '0;
            is_mul       <= 1'b0;
            mul_high     <= 1'b0;
            is_rem       <= 1'b0;
            neg          <= 1'b0;
            w_q          <= 1'b0;
        end else if (flush_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            cnt          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        is_mul      <= |mdu_info_i[3:0];
                        mul_high    <= |mdu_info_i[3:1];
                        is_rem      <= mdu_info_i[6] | mdu_info_i[7];
                        neg         <= (mdu_info_i[6] | mdu_info_i[7]) ? sa : (sa ^ sb);
                        w_q         <= req_w;
                        if (fast) begin
                            mdu_res_o    <= fast_res;
                            resp_valid_o <= 1'b1;
                            state        <= DONE;
                        end else begin
                            cnt   <= (req_w || XLEN == 32) ? 7'd32 : 7'd64;
                            acc   <= '0;
                            opa   <= (|mdu_info_i[3:0]) ? PW'(a_mag) : PW'(div_dvd);
                            opb   <= b_mag;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (is_mul) begin
                        acc <= mul_acc_nx;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end else begin
                        acc[XLEN-1:0] <= rem_nx;
                        opa[XLEN-1:0] <= q_nx;
                    end
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        mdu_res_o    <= calc_res;
                        resp_valid_o <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
